lsu_mem_port: RTL and testbench

- Load/store unit sitting between the core datapath and the word-addressed data RAM (synchronous write, asynchronous read, word-only).
- Accepts byte/halfword/word load and store requests over a valid/ready handshake and translates byte addresses to RAM word indices.
- Performs read-modify-write for sub-word stores and extracts plus sign/zero-extends sub-word loads.
- Returns one response per request, with an error flag for misaligned accesses.

---
 rtl/lsu_mem_port.sv | 194 +++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store unit between the core datapath and a word-addressed
// data RAM (synchronous write, asynchronous read). Handles byte/half/word
// accesses, read-modify-write for sub-word stores and load extension.
// Optional feature macro: LSU_BOUNDS_CHECK_EN (faults on address bits above
// the RAM range instead of wrapping).
module lsu_mem_port #(
  parameter  int unsigned XLen      = 32,
  parameter  int unsigned NPos      = 1024,
  localparam int unsigned NPosWidth = $clog2(NPos)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [XLen-1:0]      req_addr_i,
  input  logic [1:0]           req_size_i,
  input  logic                 req_unsigned_i,
  input  logic [XLen-1:0]      req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [XLen-1:0]      rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic [NPosWidth-1:0] mem_a_o,
  output logic                 mem_we_o,
  output logic [XLen-1:0]      mem_wd_o,
  input  logic [XLen-1:0]      mem_rd_i
);

  localparam int unsigned AddrHiLsb = NPosWidth + 2;
  localparam logic [1:0]  SizeByte  = 2'b00;
  localparam logic [1:0]  SizeHalf  = 2'b01;
  localparam logic [1:0]  SizeWord  = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t state_q, state_d;

  logic                 we_q, unsigned_q;
  logic [1:0]           size_q, lane_q;
  logic [XLen-1:0]      wdata_q;
  logic                 latch_req;

  logic                 req_ready_d, rsp_valid_d, rsp_err_d, mem_we_d;
  logic [XLen-1:0]      rsp_rdata_d, mem_wd_d;
  logic [NPosWidth-1:0] mem_a_d;

  logic                 req_bad_c, addr_oob_c;
  logic [4:0]           lane_sh;
  logic [XLen-1:0]      rd_lane, load_ext, lane_mask, merge_c;

`ifdef LSU_BOUNDS_CHECK_EN
  // Any address bit above the RAM range faults the request
  assign addr_oob_c = |req_addr_i[XLen-1:AddrHiLsb];
`else
  // Upper address bits are discarded so accesses wrap modulo the RAM size
  logic unused_addr_hi;
  assign unused_addr_hi = |req_addr_i[XLen-1:AddrHiLsb];
  assign addr_oob_c     = 1'b0;
`endif

  // Request legality: illegal size, misalignment or out-of-range address
  always_comb begin
    req_bad_c = (req_size_i == 2'b11)
              | ((req_size_i == SizeHalf) & req_addr_i[0])
              | ((req_size_i == SizeWord) & (req_addr_i[1:0] != 2'b00))
              | addr_oob_c;
  end

  // Load lane extraction with sign/zero extension
  always_comb begin
    lane_sh = {lane_q, 3'b000};
    rd_lane = mem_rd_i >> lane_sh;
    case (size_q)
      SizeByte: load_ext = unsigned_q ? XLen'(rd_lane[7:0])
                                      : {{(XLen-8){rd_lane[7]}}, rd_lane[7:0]};
      SizeHalf: load_ext = unsigned_q ? XLen'(rd_lane[15:0])
                                      : {{(XLen-16){rd_lane[15]}}, rd_lane[15:0]};
      default:  load_ext = rd_lane;
    endcase
  end

  // Sub-word store merge of the new lane into the current RAM word
  always_comb begin
    lane_mask = (size_q == SizeByte) ? XLen'(8'hFF) : XLen'(16'hFFFF);
    merge_c   = (mem_rd_i & ~(lane_mask << lane_sh)) | ((wdata_q & lane_mask) << lane_sh);
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and next-output logic; outputs are registered from the *_d values
  always_comb begin
    state_d     = state_q;
    latch_req   = 1'b0;
    rsp_valid_d = rsp_valid_o;
    rsp_err_d   = rsp_err_o;
    rsp_rdata_d = rsp_rdata_o;
    mem_a_d     = mem_a_o;
    mem_we_d    = 1'b0;
    mem_wd_d    = mem_wd_o;
    case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          latch_req   = 1'b1;
          rsp_rdata_d = '0;
          if (req_bad_c) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
            mem_a_d = req_addr_i[NPosWidth+1:2];
            if (req_we_i && (req_size_i == SizeWord)) begin
              mem_we_d = 1'b1;
              mem_wd_d = req_wdata_i;
            end
          end
        end
      end
      ACCESS: begin
        if (!we_q) begin
          rsp_rdata_d = load_ext;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (size_q == SizeWord) begin
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          // mem_wd_o doubles as the merge register for the WRITE cycle
          mem_we_d = 1'b1;
          mem_wd_d = merge_c;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // Registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
      mem_a_o     <= '0;
      mem_we_o    <= 1'b0;
      mem_wd_o    <= '0;
    end else begin
      req_ready_o <= req_ready_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_err_o   <= rsp_err_d;
      rsp_rdata_o <= rsp_rdata_d;
      mem_a_o     <= mem_a_d;
      mem_we_o    <= mem_we_d;
      mem_wd_o    <= mem_wd_d;
    end
  end

  // Request capture on handshake
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= 2'b00;
      lane_q     <= 2'b00;
      wdata_q    <= '0;
    end else if (latch_req) begin
      we_q       <= req_we_i;
      unsigned_q <= req_unsigned_i;
      size_q     <= req_size_i;
      lane_q     <= req_addr_i[1:0];
      wdata_q    <= req_wdata_i;
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: randomized self-checking bench for lsu_mem_port against a
// byte-level memory model. Honors LSU_BOUNDS_CHECK_EN the same way as the RTL.
module tb_lsu_mem_port;

  localparam int unsigned NWords = 1024;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [1:0]  req_size_i = '0;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [9:0]  mem_a_o;
  logic        mem_we_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;

  logic [31:0] ram [NWords];
  logic [31:0] model_mem [NWords];
  logic        init_go = 1'b0;
  int          we_count;
  int          n_checks = 0;
  int          n_fail = 0;

  lsu_mem_port #(.XLen(32), .NPos(NWords)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o),
    .mem_a_o(mem_a_o), .mem_we_o(mem_we_o), .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] bg(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'hC3A51F07;
  endfunction

  // Environment RAM: async read, sync write, with a write-pulse counter
  assign mem_rd_i = ram[mem_a_o];
  always @(posedge clk_i) begin
    if (init_go) begin
      for (int i = 0; i < int'(NWords); i++) ram[i] <= bg(i);
      we_count <= 0;
    end else if (mem_we_o) begin
      ram[mem_a_o] <= mem_wd_o;
      we_count     <= we_count + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One transaction: predicts from the byte model, drives, checks response and RAM
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata, input int hold,
                        input logic use_const, input logic [31:0] const_rd);
    int          nbytes, lane, idx, lat, we_at, wc0, guard, exp_lat, exp_we_at;
    logic        exp_err;
    logic [31:0] val, exp_rd;
    logic [7:0]  bytes [4];

    idx    = int'(addr[11:2]);
    lane   = int'(addr[1:0]);
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    exp_err = (nbytes == 0) || ((int'(addr[1:0]) % ((nbytes == 0) ? 1 : nbytes)) != 0);
`ifdef LSU_BOUNDS_CHECK_EN
    if (addr >= 32'(4 * NWords)) exp_err = 1'b1;
`endif
    exp_rd = '0;
    exp_lat = 1;
    exp_we_at = 0;
    if (!exp_err) begin
      for (int b = 0; b < 4; b++) bytes[b] = model_mem[idx][8*b +: 8];
      if (!we) begin
        val = '0;
        for (int b = 0; b < nbytes; b++) val = val | (32'(bytes[lane+b]) << (8*b));
        if (!uns && nbytes < 4 && val[8*nbytes-1]) val = val - (32'd1 << (8*nbytes));
        exp_rd  = val;
        exp_lat = 2;
      end else begin
        for (int b = 0; b < nbytes; b++) bytes[lane+b] = wdata[8*b +: 8];
        model_mem[idx] = {bytes[3], bytes[2], bytes[1], bytes[0]};
        exp_lat   = (nbytes == 4) ? 2 : 3;
        exp_we_at = (nbytes == 4) ? 1 : 2;
      end
    end

    @(negedge clk_i);
    guard = 0;
    while (!req_ready_o && guard < 10) begin @(negedge clk_i); guard++; end
    check_eq("req_ready_idle", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_size_i = size;
    req_unsigned_i = uns; req_wdata_i = wdata;
    wc0 = we_count;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    lat = 1;
    we_at = mem_we_o ? lat : 0;
    while (!rsp_valid_o && lat < 8) begin
      @(negedge clk_i);
      lat++;
      if (mem_we_o) we_at = lat;
    end
    check_eq("rsp_valid", 32'(rsp_valid_o), 32'd1);
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("we_cycle", 32'(we_at), 32'(exp_we_at));
    check_eq("rsp_err", 32'(rsp_err_o), 32'(exp_err));
    check_eq("rsp_rdata", rsp_rdata_o, exp_rd);
    if (use_const) check_eq("rsp_rdata_const", rsp_rdata_o, const_rd);
    check_eq("req_ready_busy", 32'(req_ready_o), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_i);
      check_eq("hold_valid", 32'(rsp_valid_o), 32'd1);
      check_eq("hold_rdata", rsp_rdata_o, exp_rd);
      check_eq("hold_ready", 32'(req_ready_o), 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    check_eq("post_valid", 32'(rsp_valid_o), 32'd0);
    check_eq("post_ready", 32'(req_ready_o), 32'd1);
    check_eq("we_pulses", 32'(we_count - wc0), (we && !exp_err) ? 32'd1 : 32'd0);
    check_eq("ram_word", ram[idx], model_mem[idx]);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [1:0]  s;
    int          wc0;

    for (int i = 0; i < int'(NWords); i++) model_mem[i] = bg(i);
    init_go = 1'b1;
    #2 rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    init_go = 1'b0;
    check_eq("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata_o, 32'd0);
    check_eq("rst_mem_we", 32'(mem_we_o), 32'd0);
    check_eq("rst_mem_a", 32'(mem_a_o), 32'd0);
    check_eq("rst_mem_wd", mem_wd_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("rst_req_ready", 32'(req_ready_o), 32'd1);

    // Word store/load, byte RMW, extended sub-word loads
    do_req(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 0, 1'b0, 32'h0);
    check_eq("ram4_word", ram[4], 32'hDEADBEEF);
    do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, 1'b1, 32'hDEADBEEF);
    do_req(1'b1, 32'h12, 2'd0, 1'b0, 32'h00000055, 0, 1'b0, 32'h0);
    check_eq("ram4_rmw", ram[4], 32'hDE55BEEF);
    do_req(1'b0, 32'h13, 2'd0, 1'b0, 32'h0, 0, 1'b1, 32'hFFFFFFDE);
    do_req(1'b0, 32'h13, 2'd0, 1'b1, 32'h0, 0, 1'b1, 32'h000000DE);
    do_req(1'b0, 32'h10, 2'd1, 1'b0, 32'h0, 0, 1'b1, 32'hFFFFBEEF);
    // Misaligned and illegal-size faults
    do_req(1'b1, 32'h11, 2'd1, 1'b0, 32'h1234, 0, 1'b0, 32'h0);
    do_req(1'b0, 32'h16, 2'd2, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    do_req(1'b1, 32'h14, 2'd3, 1'b0, 32'hFFFF, 0, 1'b0, 32'h0);
    // Response back-pressure
    do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 5, 1'b1, 32'hDE55BEEF);
    // Range boundary: faults with bounds checking, wraps to word 0 otherwise
    do_req(1'b0, 32'h1000, 2'd2, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    do_req(1'b1, 32'h1FFE, 2'd1, 1'b0, 32'hCAFE, 1, 1'b0, 32'h0);

    // Reset during the WRITE cycle of a byte store
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h12; req_size_i = 2'd0;
    req_wdata_i = 32'hA7;
    wc0 = we_count;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    check_eq("write_cycle_we", 32'(mem_we_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check_eq("abort_we_drop", 32'(mem_we_o), 32'd0);
    check_eq("abort_rsp_valid", 32'(rsp_valid_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("abort_ready", 32'(req_ready_o), 32'd1);
    check_eq("abort_ram4", ram[4], model_mem[4]);
    check_eq("abort_no_write", 32'(we_count - wc0), 32'd0);

    // Randomized mix over a small window so stores and loads collide
    for (int n = 0; n < 300; n++) begin
      s = ($urandom % 8 < 7) ? 2'($urandom % 3) : 2'd3;
      a = 32'($urandom % 64);
      if ($urandom % 4 != 0) begin
        if (s == 2'd1) a[0] = 1'b0;
        else if (s == 2'd2) a[1:0] = 2'b00;
      end
      if ($urandom % 8 == 0) a[31:12] = 20'($urandom) | 20'd1;
      d = $urandom;
      do_req(1'($urandom % 2), a, s, 1'($urandom % 2), d, int'($urandom % 3), 1'b0, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
